match_event_logger: RTL and testbench
=====================================

Name: match_event_logger

Overview:
- Downstream consumer of the serial-pattern detector's Mealy match output z. Sits directly after the detector.
- Timestamps every match against a free-running cycle counter and buffers the timestamps in a small FIFO. A host reads them over a valid/ready handshake.
- Also keeps a saturating total match count and a sticky overflow flag for dropped events.

Parameters:
- TS_W, 16, width of timestamp counter and FIFO entries
- DEPTH, 4, FIFO depth in entries (power of 2, >=2)
- CNT_W, 8, width of saturating match counter

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- en  input  1  logging enable; gates timestamp advance and match capture
- clr  input  1  synchronous clear of all state
- match_in  input  1  detector match pulse (z), sampled at posedge clk
- evt_valid  output  1  FIFO head holds an event
- evt_ts  output  TS_W  timestamp at FIFO head
- evt_ready  input  1  host accepts head this cycle
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy
- match_cnt  output  CNT_W  total matches seen, saturating
- ovf  output  1  sticky: at least one event dropped

Behaviour:
- Reset (rstn=0, async): ts=0, FIFO empty, evt_valid=0, evt_ts=0, fill=0, match_cnt=0, ovf=0.
- Priority per posedge: rstn > clr > normal operation.
- Timestamp counter ts:
  - If en=1, ts increments by 1 each cycle and wraps from 2^TS_W-1 to 0.
  - If en=0, ts holds.
- Capture:
  - A push request occurs when en=1 and match_in=1 at a posedge.
  - The pushed entry is the ts value before that edge's increment.
  - match_in is ignored when en=0.
- Latency: evt_valid rises on the edge that writes into an empty FIFO, i.e. visible 1 cycle after the match cycle. evt_ts is valid in that same cycle (first-word fall-through).
- Pop: occurs when evt_valid=1 and evt_ready=1 at the posedge. The head advances on that edge. evt_ready is ignored when evt_valid=0.
- Simultaneous push and pop:
  - Both are performed; fill is unchanged, including when the FIFO is full.
  - When the FIFO is empty, no pop is possible; the push proceeds.
- Full, push without pop: the entry is dropped, ovf is set to 1 and stays sticky, and FIFO contents are unchanged.
- match_cnt:
  - Increments on every push request, including dropped ones.
  - Saturates at 2^CNT_W-1 and never wraps.
- fill: ranges 0..DEPTH and always matches the number of stored entries. evt_valid == (fill != 0).
- Pointers: log2(DEPTH) bits, wrapping naturally. Full/empty are derived from the fill counter.
- clr=1 (sync):
  - Sets ts=0, empties the FIFO, match_cnt=0, ovf=0.
  - A match or pop in the same cycle is discarded.
  - Outputs show cleared values from the next cycle.
- Mid-operation async reset: all state clears immediately; no partial entries survive.
- evt_ts when FIFO empty: don't-care for the consumer; the implementation drives 0 after reset/clr.

Decomposition:
- Shared header: default TS_W/DEPTH/CNT_W localparams, reused by the detector top-level wrapper.
- Natural sub-module: evt_fifo.
  - Synchronous FWFT FIFO parameterised by width/depth.
  - Ports: push, pop, din, dout, empty, full, fill; clk/rstn/clr.
- The logger instantiates evt_fifo and holds the ts counter, match_cnt and ovf logic.

Test Plan:
- Reset then en=1 with match_in pulses at cycles 3 and 7 (ts=3, 7), evt_ready=0 -> evt_valid=1 from cycle 4; fill 1 then 2; evt_ts=3; match_cnt=2.
- Then evt_ready=1 for 2 cycles -> evt_ts 3 then 7 popped in order; evt_valid=0 after; fill=0; ovf=0.
- evt_ready=0 with 6 matches -> fill=4, first 4 timestamps retained, ovf=1, match_cnt=6. A subsequent pop+match in the same cycle keeps fill=4 with no further drop.
- match_in=1 held for 300 cycles with CNT_W=8 -> match_cnt sticks at 255.
- TS_W=4, en=1 for 20 cycles with a match at cycle 17 -> logged ts=1 (wrap verified). en=0 match -> not logged, ts frozen.
- clr asserted with fill=3, ovf=1, and a match in the same cycle -> next cycle fill=0, evt_valid=0, match_cnt=0, ovf=0, ts=0. Async rstn low mid-stream -> immediate clear.

Source files
------------

// File: rtl/match_event_logger_pkg.sv
// Shared sizing defaults for the match event logger and the detector wrapper.
package match_event_logger_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/match_event_logger_if.sv
// Event read handshake: the logger presents timestamps, the host accepts them.
interface match_event_logger_if
    import match_event_logger_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
) ();

    logic            evt_valid;
    logic [TS_W-1:0] evt_ts;
    logic            evt_ready;

    modport master (output evt_valid, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, output evt_ready);

endinterface

// File: rtl/match_event_logger_evt_fifo.sv
// First-word fall-through FIFO; occupancy counter drives full/empty.
module evt_fifo
    import match_event_logger_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign fill    = cnt;
    assign do_pop  = pop && !empty && !clr;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop) && !clr;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps detector matches into a FIFO; keeps a saturating match count and sticky drop flag.
module match_event_logger
    import match_event_logger_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    match_in,
    match_event_logger_if.master    evt,
    output logic [$clog2(DEPTH):0]  fill,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    ovf
);

    logic [TS_W-1:0] ts;
    logic            push_req;
    logic            pop_req;
    logic            empty;
    logic            full;

    assign push_req      = en && match_in;
    assign pop_req       = evt.evt_ready && !empty;
    assign evt.evt_valid = !empty;

    evt_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (push_req),
        .pop   (pop_req),
        .din   (ts),
        .dout  (evt.evt_ts),
        .empty (empty),
        .full  (full),
        .fill  (fill)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts        <= '0;
            match_cnt <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            ts        <= '0;
            match_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en) ts <= ts + TS_W'(1);
            // Dropped events still count as matches.
            if (push_req && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
            if (push_req && full && !pop_req) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed stimulus against a queue-based reference model of the logger.
module tb_match_event_logger;

    localparam int TS_W  = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TS_MOD  = 1 << TS_W;

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic clr;
    logic match_in;
    logic [$clog2(DEPTH):0] fill;
    logic [CNT_W-1:0] match_cnt;
    logic ovf;

    match_event_logger_if #(.TS_W(TS_W)) evt ();

    match_event_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clr       (clr),
        .match_in  (match_in),
        .evt       (evt),
        .fill      (fill),
        .match_cnt (match_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model: expected FIFO contents plus counters.
    int mq[$];
    int m_ts  = 0;
    int m_cnt = 0;
    int m_ovf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ts  = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    // Applies one clock edge's worth of the logger rules to the model.
    task automatic model_step(input bit e, input bit c, input bit m, input bit r);
        bit pop;
        if (c) begin
            model_clear();
            return;
        end
        pop = r && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (e && m) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back(m_ts);
        end
        if (e) m_ts = (m_ts + 1) % TS_MOD;
    endtask

    task automatic cyc(input bit e, input bit c, input bit m, input bit r);
        @(negedge clk);
        en = e; clr = c; match_in = m; evt.evt_ready = r;
        @(posedge clk);
        #1;
        model_step(e, c, m, r);
    endtask

    task automatic async_reset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; match_in = 1'b0; evt.evt_ready = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        chk("rst_async_valid", evt.evt_valid, 0);
        chk("rst_async_fill", fill, 0);
        chk("rst_async_cnt", match_cnt, 0);
        chk("rst_async_ovf", ovf, 0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: compares DUT outputs to the model between edges.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                chk("evt_valid", evt.evt_valid, (mq.size() != 0) ? 1 : 0);
                chk("fill", fill, mq.size());
                chk("match_cnt", match_cnt, m_cnt);
                chk("ovf", ovf, m_ovf);
                if (mq.size() != 0) chk("evt_ts", evt.evt_ts, mq[0]);
                else chk("evt_ts_empty", evt.evt_ts, 0);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        en = 1'b0; clr = 1'b0; match_in = 1'b0; evt.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", evt.evt_valid, 0);
        chk("reset_ts", evt.evt_ts, 0);
        chk("reset_fill", fill, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("reset_ovf", ovf, 0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        mon_on = 1'b1;

        // Matches at cycles 3 and 7, host stalled, then drained.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, (i == 3 || i == 7), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Overflow, then pop+match while full.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation of the match counter.
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

        // Clear with fill=3, ovf set and a simultaneous match.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Timestamp wrap: match at cycle 17 logs ts=1.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, (i == 17), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // Disabled matches are ignored and ts freezes.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        async_reset();

        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) async_reset();
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 4), $urandom_range(0, 1));
        end

        @(negedge clk);
        #2;
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
